// File: rtl/async_fifo_rd_stream_if.sv
// Signal bundle between the FIFO read port, the drain stage and the downstream stream consumer.
// The master modport is the drain stage; the slave modport is the FIFO/consumer side.
interface async_fifo_rd_stream_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             fifo_rd_empty;
    logic [WIDTH-1:0] fifo_data_out;
    logic             fifo_rden;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             burst_done;
    logic [1:0]       level;

    modport master (
        input  en, fifo_rd_empty, fifo_data_out, m_ready,
        output fifo_rden, m_valid, m_data, m_last, burst_done, level
    );

    modport slave (
        output en, fifo_rd_empty, fifo_data_out, m_ready,
        input  fifo_rden, m_valid, m_data, m_last, burst_done, level
    );
endinterface

// File: rtl/async_fifo_rd_stream.sv
// Drains a first-word-fall-through FIFO into a registered valid/ready stream through a
// two-entry skid buffer, framing fixed-length bursts with m_last and a burst_done pulse.
module async_fifo_rd_stream #(
    parameter int WIDTH     = 8,
    parameter int BURST_LEN = 4
) (
    input  logic                   rd_clk,
    input  logic                   arresetn,
    async_fifo_rd_stream_if.master bus
);
    localparam logic [15:0] LAST_BEAT = 16'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           r_state, w_state_next;
    logic [WIDTH-1:0] r_buf0, r_buf1, w_buf0_next, w_buf1_next;
    logic [15:0]      r_beat, w_beat_next;
    logic             r_burst_done, w_burst_done_next;
    logic             w_push, w_pop, w_valid, w_last;

    // The read request looks only at registered occupancy, so m_ready never reaches fifo_rden.
    assign w_valid = (r_state != EMPTY);
    assign w_last  = w_valid & (r_beat == LAST_BEAT);
    assign w_push  = arresetn & bus.en & ~bus.fifo_rd_empty & (r_state != FULL);
    assign w_pop   = w_valid & bus.m_ready;

    always_ff @(posedge rd_clk or negedge arresetn) begin
        if (!arresetn) begin
            r_state      <= EMPTY;
            r_buf0       <= '0;
            r_buf1       <= '0;
            r_beat       <= '0;
            r_burst_done <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_buf0       <= w_buf0_next;
            r_buf1       <= w_buf1_next;
            r_beat       <= w_beat_next;
            r_burst_done <= w_burst_done_next;
        end
    end

    always_comb begin
        w_state_next      = r_state;
        w_buf0_next       = r_buf0;
        w_buf1_next       = r_buf1;
        w_beat_next       = r_beat;
        w_burst_done_next = w_pop & w_last;
        case (r_state)
            EMPTY: begin
                if (w_push) begin
                    w_buf0_next  = bus.fifo_data_out;
                    w_state_next = ONE;
                end
            end
            ONE: begin
                if (w_push && w_pop) begin
                    w_buf0_next = bus.fifo_data_out;
                end else if (w_push) begin
                    w_buf1_next  = bus.fifo_data_out;
                    w_state_next = FULL;
                end else if (w_pop) begin
                    w_state_next = EMPTY;
                end
            end
            FULL: begin
                if (w_pop) begin
                    w_buf0_next  = r_buf1;
                    w_state_next = ONE;
                end
            end
            default: w_state_next = EMPTY;
        endcase
        if (w_pop) begin
            w_beat_next = (r_beat == LAST_BEAT) ? 16'd0 : r_beat + 16'd1;
        end
    end

    always_comb begin
        bus.fifo_rden  = w_push;
        bus.m_valid    = w_valid;
        bus.m_data     = r_buf0;
        bus.m_last     = w_last;
        bus.burst_done = r_burst_done;
        bus.level      = r_state;
    end
endmodule

// File: tb/tb_async_fifo_rd_stream.sv
// Directed bench for async_fifo_rd_stream with a behavioural FWFT FIFO and a handshake log.
module tb_async_fifo_rd_stream;
    localparam int WIDTH = 8;

    logic clk = 1'b0;
    logic arresetn;
    always #5 clk = ~clk;

    async_fifo_rd_stream_if #(.WIDTH(WIDTH)) bus ();

    async_fifo_rd_stream #(.WIDTH(WIDTH), .BURST_LEN(4)) dut (
        .rd_clk   (clk),
        .arresetn (arresetn),
        .bus      (bus)
    );

    logic [WIDTH-1:0] fifo_mem [0:255];
    logic [7:0]       wr_ptr = 8'd0;
    logic [7:0]       rd_ptr = 8'd0;

    assign bus.fifo_rd_empty = (rd_ptr == wr_ptr);
    assign bus.fifo_data_out = fifo_mem[rd_ptr];

    always @(posedge clk) begin
        if (bus.fifo_rden) rd_ptr <= rd_ptr + 8'd1;
    end

    logic [WIDTH:0] hs_log [$];
    int             viol = 0;

    always @(posedge clk) begin
        if (bus.m_valid && bus.m_ready) hs_log.push_back({bus.m_last, bus.m_data});
        if (bus.level > 2'd2 || (bus.level == 2'd2 && bus.fifo_rden)) viol <= viol + 1;
    end

    int n_cmp = 0;
    int n_err = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d);
        fifo_mem[wr_ptr] = d;
        wr_ptr = wr_ptr + 8'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int base;
        int base2;
        logic [3:0] pat;
        logic [WIDTH:0] e;
        pat = 4'b1001;

        // Reset then idle
        arresetn   = 1'b0;
        bus.en     = 1'b1;
        bus.m_ready = 1'b1;
        repeat (3) tick();
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_data", 32'(bus.m_data), 32'd0);
        chk("rst_last", 32'(bus.m_last), 32'd0);
        chk("rst_done", 32'(bus.burst_done), 32'd0);
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_rden_empty", 32'(bus.fifo_rden), 32'd0);
        for (int k = 1; k <= 8; k++) push_word(8'(k));
        #1;
        chk("rst_rden_nonempty", 32'(bus.fifo_rden), 32'd0);

        // Streaming 0x01..0x08
        arresetn = 1'b1;
        #1;
        chk("str_rden_first", 32'(bus.fifo_rden), 32'd1);
        chk("str_valid_first", 32'(bus.m_valid), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            tick();
            chk("str_valid", 32'(bus.m_valid), 32'd1);
            chk("str_data", 32'(bus.m_data), 32'(k));
            chk("str_last", 32'(bus.m_last), 32'((k % 4) == 0));
            chk("str_done", 32'(bus.burst_done), 32'(k == 5));
            chk("str_level", 32'(bus.level), 32'd1);
            chk("str_rden", 32'(bus.fifo_rden), 32'(k < 8));
        end
        tick();
        chk("str_valid_end", 32'(bus.m_valid), 32'd0);
        chk("str_done_end", 32'(bus.burst_done), 32'd1);
        tick();
        chk("str_done_clear", 32'(bus.burst_done), 32'd0);

        // Back-pressure with ready pattern 1,0,0,1 over 16 words
        base = hs_log.size();
        for (int i = 0; i < 16; i++) push_word(8'(8'h20 + i));
        for (int cyc = 0; cyc < 200 && hs_log.size() < base + 16; cyc++) begin
            bus.m_ready = pat[cyc % 4];
            tick();
        end
        bus.m_ready = 1'b1;
        chk("bp_count", 32'(hs_log.size() - base), 32'd16);
        chk("bp_level_rden_viol", 32'(viol), 32'd0);
        for (int i = 0; i < 16; i++) begin
            e = {((i % 4) == 3), 8'(8'h20 + i)};
            chk("bp_word", 32'(hs_log[base + i]), 32'(e));
        end
        repeat (3) tick();

        // Empty gap keeps the beat count
        base = hs_log.size();
        push_word(8'h10);
        push_word(8'h11);
        repeat (3) tick();
        repeat (5) tick();
        chk("gap_valid", 32'(bus.m_valid), 32'd0);
        chk("gap_rden", 32'(bus.fifo_rden), 32'd0);
        push_word(8'h12);
        push_word(8'h13);
        repeat (3) tick();
        chk("gap_done", 32'(bus.burst_done), 32'd1);
        tick();
        chk("gap_done_clear", 32'(bus.burst_done), 32'd0);
        chk("gap_count", 32'(hs_log.size() - base), 32'd4);
        chk("gap_w0", 32'(hs_log[base + 0]), 32'h010);
        chk("gap_w1", 32'(hs_log[base + 1]), 32'h011);
        chk("gap_w2", 32'(hs_log[base + 2]), 32'h012);
        chk("gap_w3", 32'(hs_log[base + 3]), 32'h113);

        // Enable drop with a full buffer
        bus.m_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_word(8'(8'h30 + i));
        repeat (2) tick();
        chk("en_full_level", 32'(bus.level), 32'd2);
        chk("en_full_rden", 32'(bus.fifo_rden), 32'd0);
        chk("en_full_data", 32'(bus.m_data), 32'h30);
        bus.en = 1'b0;
        bus.m_ready = 1'b1;
        tick();
        chk("en_drain1_level", 32'(bus.level), 32'd1);
        chk("en_drain1_data", 32'(bus.m_data), 32'h31);
        chk("en_drain1_rden", 32'(bus.fifo_rden), 32'd0);
        tick();
        chk("en_drain2_level", 32'(bus.level), 32'd0);
        chk("en_drain2_rden", 32'(bus.fifo_rden), 32'd0);
        tick();
        chk("en_idle_level", 32'(bus.level), 32'd0);
        bus.en = 1'b1;
        #1;
        chk("en_resume_rden", 32'(bus.fifo_rden), 32'd1);
        tick();
        chk("en_resume_data", 32'(bus.m_data), 32'h32);
        chk("en_resume_valid", 32'(bus.m_valid), 32'd1);
        tick();
        chk("en_last_data", 32'(bus.m_data), 32'h33);
        chk("en_last_flag", 32'(bus.m_last), 32'd1);
        tick();
        chk("en_done", 32'(bus.burst_done), 32'd1);
        chk("en_valid_end", 32'(bus.m_valid), 32'd0);

        // Reset mid-burst with two words buffered
        base = hs_log.size();
        for (int i = 0; i < 8; i++) push_word(8'(8'h40 + i));
        tick();
        tick();
        tick();
        chk("mid_data_b2", 32'(bus.m_data), 32'h42);
        bus.m_ready = 1'b0;
        tick();
        chk("mid_level_full", 32'(bus.level), 32'd2);
        arresetn = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.m_valid), 32'd0);
        chk("mid_rst_level", 32'(bus.level), 32'd0);
        chk("mid_rst_data", 32'(bus.m_data), 32'd0);
        chk("mid_rst_last", 32'(bus.m_last), 32'd0);
        chk("mid_rst_rden", 32'(bus.fifo_rden), 32'd0);
        repeat (2) tick();
        chk("mid_pre_count", 32'(hs_log.size() - base), 32'd2);
        base2 = hs_log.size();
        arresetn = 1'b1;
        bus.m_ready = 1'b1;
        repeat (6) tick();
        chk("mid_post_count", 32'(hs_log.size() - base2), 32'd4);
        chk("mid_w0", 32'(hs_log[base2 + 0]), 32'h044);
        chk("mid_w1", 32'(hs_log[base2 + 1]), 32'h045);
        chk("mid_w2", 32'(hs_log[base2 + 2]), 32'h046);
        chk("mid_w3", 32'(hs_log[base2 + 3]), 32'h147);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
